// File: rtl/gate_model_test_sequencer_pkg.sv
// Shared types and step functions for the gate-model test sequencer:
// FSM state encoding, LFSR/MISR tap constants and their next-state functions.
package gate_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        APPLY   = 3'd2,
        SETTLE  = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Fibonacci LFSR taps at bits 23, 22, 21, 16
    localparam logic [23:0] LFSR_TAP = 24'hE10000;
    // MISR feedback taps at bits 15, 14, 12, 3
    localparam logic [15:0] MISR_TAP = 16'hD008;

    function automatic logic [23:0] lfsr_step(input logic [23:0] l);
        return {l[22:0], ^(l & LFSR_TAP)};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [15:0] d);
        return {m[14:0], ^(m & MISR_TAP)} ^ d;
    endfunction

endpackage

// File: rtl/gate_model_test_sequencer_sig_misr.sv
// Multiple-input signature register: compresses one response word per enabled
// cycle into a running signature. clr has priority over en.
module sig_misr
    import gate_seq_pkg::*;
#(
    parameter int SIG_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [SIG_W-1:0] data,
    output logic [SIG_W-1:0] misr
);

    logic [SIG_W-1:0] misr_r;

    // Signature register: clear, fold one word, or hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misr_r <= {SIG_W{1'b0}};
        end else if (clr) begin
            misr_r <= {SIG_W{1'b0}};
        end else if (en) begin
            misr_r <= misr_step(misr_r, data);
        end else begin
            misr_r <= misr_r;
        end
    end

    assign misr = misr_r;

endmodule

// File: rtl/gate_model_test_sequencer.sv
// Gate-model test sequencer: drives LFSR vectors into a combinational gate
// model, waits SETTLE_CYC cycles, folds each response into a MISR and reports
// the final signature. Optional macro GOLDEN_CMP_EN adds expected_sig/pass.
module gate_model_test_sequencer
    import gate_seq_pkg::*;
#(
    parameter int IN_W       = 24,
    parameter int OUT_W      = 10,
    parameter int SIG_W      = 16,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [IN_W-1:0]  seed,
    input  logic [CNT_W-1:0] num_vectors,
`ifdef GOLDEN_CMP_EN
    input  logic [SIG_W-1:0] expected_sig,
    output logic             pass,
`endif
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] vec_count,
    output logic [SIG_W-1:0] signature
);

    localparam int              TW        = $clog2(SETTLE_CYC + 1);
    localparam logic [TW-1:0]   SETTLE_LD = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0]   TMR_ONE   = TW'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [IN_W-1:0] LFSR_ONE  = IN_W'(1'b1);

    state_t           state_r;
    state_t           state_s;
    logic [IN_W-1:0]  seed_r;
    logic [CNT_W-1:0] num_r;
    logic [IN_W-1:0]  lfsr_r;
    logic [TW-1:0]    timer_r;
    logic [IN_W-1:0]  dut_in_r;
    logic             busy_r;
    logic             done_r;
    logic [CNT_W-1:0] vec_count_r;
    logic [SIG_W-1:0] signature_r;
    logic [SIG_W-1:0] misr_s;
    logic             misr_clr_s;
    logic             misr_en_s;
`ifdef GOLDEN_CMP_EN
    logic [SIG_W-1:0] exp_r;
    logic             pass_r;
`endif

    assign misr_clr_s = (state_r == LOAD) && !abort;
    assign misr_en_s  = (state_r == CAPTURE) && !abort;

    sig_misr #(.SIG_W(SIG_W)) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (misr_clr_s),
        .en    (misr_en_s),
        .data  ({{(SIG_W-OUT_W){1'b0}}, dut_out}),
        .misr  (misr_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; abort returns to IDLE from any busy state
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = start ? LOAD : IDLE;
            LOAD:    state_s = abort ? IDLE : ((num_r == {CNT_W{1'b0}}) ? DONE : APPLY);
            APPLY:   state_s = abort ? IDLE : SETTLE;
            SETTLE:  state_s = abort ? IDLE : ((timer_r == {TW{1'b0}}) ? CAPTURE : SETTLE);
            CAPTURE: state_s = abort ? IDLE : ((vec_count_r == (num_r - CNT_ONE)) ? DONE : APPLY);
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Datapath and registered outputs, updated per state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_r      <= {IN_W{1'b0}};
            num_r       <= {CNT_W{1'b0}};
            lfsr_r      <= {IN_W{1'b0}};
            timer_r     <= {TW{1'b0}};
            dut_in_r    <= {IN_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            vec_count_r <= {CNT_W{1'b0}};
            signature_r <= {SIG_W{1'b0}};
`ifdef GOLDEN_CMP_EN
            exp_r       <= {SIG_W{1'b0}};
            pass_r      <= 1'b0;
`endif
        end else begin
            busy_r <= (state_s != IDLE);
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        seed_r <= seed;
                        num_r  <= num_vectors;
`ifdef GOLDEN_CMP_EN
                        exp_r  <= expected_sig;
`endif
                    end
                end
                LOAD: begin
                    if (!abort) begin
                        // an all-zero seed would lock the LFSR, so substitute 1
                        lfsr_r      <= (seed_r == {IN_W{1'b0}}) ? LFSR_ONE : seed_r;
                        vec_count_r <= {CNT_W{1'b0}};
`ifdef GOLDEN_CMP_EN
                        pass_r      <= 1'b0;
`endif
                    end
                end
                APPLY: begin
                    if (!abort) begin
                        dut_in_r <= lfsr_r;
                        timer_r  <= SETTLE_LD;
                    end
                end
                SETTLE: begin
                    if (!abort && (timer_r != {TW{1'b0}})) begin
                        timer_r <= timer_r - TMR_ONE;
                    end
                end
                CAPTURE: begin
                    if (!abort) begin
                        lfsr_r      <= lfsr_step(lfsr_r);
                        vec_count_r <= vec_count_r + CNT_ONE;
                    end
                end
                DONE: begin
                    if (!abort) begin
                        done_r      <= 1'b1;
                        signature_r <= misr_s;
`ifdef GOLDEN_CMP_EN
                        pass_r      <= (misr_s == exp_r);
`endif
                    end
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
`ifdef GOLDEN_CMP_EN
            if (abort && (state_r != IDLE)) begin
                pass_r <= 1'b0;
            end
`endif
        end
    end

    assign dut_in    = dut_in_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign vec_count = vec_count_r;
    assign signature = signature_r;
`ifdef GOLDEN_CMP_EN
    assign pass      = pass_r;
`endif

endmodule

// File: tb/tb_gate_model_test_sequencer.sv
// Self-checking bench for gate_model_test_sequencer: directed table rows,
// hand-written abort / reset / held-start sequences, and randomized runs
// compared against a behavioural signature model. Optional GOLDEN_CMP_EN.
module tb_gate_model_test_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [23:0] seed;
    logic [15:0] num_vectors;
    logic [23:0] dut_in;
    logic [9:0]  dut_out;
    logic        busy;
    logic        done;
    logic [15:0] vec_count;
    logic [15:0] signature;
    logic        ones_mode;
`ifdef GOLDEN_CMP_EN
    logic [15:0] expected_sig;
    logic        pass;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // combinational stand-in for the gate-library model
    function automatic logic [9:0] gate_fn(input logic [23:0] x);
        return x[9:0] ^ x[19:10] ^ {x[23:20], x[5:0]};
    endfunction

    assign dut_out = ones_mode ? 10'h3FF : gate_fn(dut_in);

    gate_model_test_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .seed        (seed),
        .num_vectors (num_vectors),
`ifdef GOLDEN_CMP_EN
        .expected_sig(expected_sig),
        .pass        (pass),
`endif
        .dut_in      (dut_in),
        .dut_out     (dut_out),
        .busy        (busy),
        .done        (done),
        .vec_count   (vec_count),
        .signature   (signature)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // reference: next LFSR value as shift-left-by-one plus parity of taps
    function automatic logic [23:0] ref_lfsr(input logic [23:0] l);
        logic fb;
        fb = l[23] ^ l[22] ^ l[21] ^ l[16];
        return ((l << 1) & 24'hFFFFFF) | {23'd0, fb};
    endfunction

    function automatic logic [15:0] ref_misr(input logic [15:0] m, input logic [15:0] d);
        logic fb;
        fb = m[15] ^ m[14] ^ m[12] ^ m[3];
        return (((m << 1) & 16'hFFFF) | {15'd0, fb}) ^ d;
    endfunction

    // whole-run model: expected signature and last vector applied
    task automatic model(input logic [23:0] s, input logic [15:0] n, input logic ones,
                         output logic [15:0] sig, output logic [23:0] last);
        logic [23:0] l;
        logic [9:0]  r;
        l    = (s == 24'd0) ? 24'd1 : s;
        sig  = 16'd0;
        last = 24'd0;
        for (int i = 0; i < int'(n); i++) begin
            r    = ones ? 10'h3FF : gate_fn(l);
            sig  = ref_misr(sig, {6'd0, r});
            last = l;
            l    = ref_lfsr(l);
        end
    endtask

    // start a run, optionally holding start, and wait (bounded) for done
    task automatic run(input logic [23:0] s, input logic [15:0] n, input logic hold,
                       input int budget, output int cyc, output logic ok,
                       output logic [15:0] sig, output logic [15:0] vc,
                       output logic [23:0] din, output logic bsy);
        @(negedge clk);
        seed        = s;
        num_vectors = n;
        start       = 1'b1;
        cyc = 0; ok = 1'b0; sig = 16'd0; vc = 16'd0; din = 24'd0; bsy = 1'b1;
        while (cyc < budget && !ok) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done) begin
                ok = 1'b1; sig = signature; vc = vec_count; din = dut_in; bsy = busy;
            end
            start = hold && !ok;
        end
        start = 1'b0;
        check("done_seen", 32'(ok), 32'd1);
    endtask

    typedef struct {
        logic [23:0] seed;
        logic [15:0] n;
        logic [15:0] sig;
        int          cyc;
        logic [23:0] din;
    } vec_t;

    vec_t        tbl[4];
    int          cyc;
    logic        ok, bsy;
    logic [15:0] sig, vc, esig, prev_sig;
    logic [23:0] din, edin, s;
    logic [15:0] n;
    int          dcount;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; seed = 24'd0; num_vectors = 16'd0;
        ones_mode = 1'b1;
`ifdef GOLDEN_CMP_EN
        expected_sig = 16'd0;
`endif
        tbl[0] = '{seed: 24'h000001, n: 16'd1, sig: 16'h03FF, cyc: 7,  din: 24'h000001};
        tbl[1] = '{seed: 24'h000001, n: 16'd2, sig: 16'h0400, cyc: 11, din: 24'h000002};
        tbl[2] = '{seed: 24'h000000, n: 16'd1, sig: 16'h03FF, cyc: 7,  din: 24'h000001};
        tbl[3] = '{seed: 24'h000005, n: 16'd0, sig: 16'h0000, cyc: 3,  din: 24'h000001};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dut_in", 32'(dut_in), 32'd0);
        check("reset_sig", 32'(signature), 32'd0);
        check("reset_vc", 32'(vec_count), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        // directed table
        for (int i = 0; i < 4; i++) begin
            run(tbl[i].seed, tbl[i].n, 1'b0, 40, cyc, ok, sig, vc, din, bsy);
            check($sformatf("tbl%0d_cycles", i), 32'(cyc), 32'(tbl[i].cyc));
            check($sformatf("tbl%0d_sig", i), 32'(sig), 32'(tbl[i].sig));
            check($sformatf("tbl%0d_vc", i), 32'(vc), 32'(tbl[i].n));
            check($sformatf("tbl%0d_din", i), 32'(din), 32'(tbl[i].din));
            check($sformatf("tbl%0d_busy", i), 32'(bsy), 32'd0);
            @(negedge clk);
            check($sformatf("tbl%0d_done_1cyc", i), 32'(done), 32'd0);
        end

`ifdef GOLDEN_CMP_EN
        expected_sig = 16'h0400;
        run(24'h000001, 16'd2, 1'b0, 40, cyc, ok, sig, vc, din, bsy);
        check("pass_match", 32'(pass), 32'd1);
        expected_sig = 16'h0401;
        run(24'h000001, 16'd2, 1'b0, 40, cyc, ok, sig, vc, din, bsy);
        check("pass_mismatch", 32'(pass), 32'd0);
`endif

        // randomized runs against the behavioural model
        ones_mode = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s = (i == 0) ? 24'd0 : 24'($urandom);
            n = 16'($urandom_range(1, 30));
            model(s, n, 1'b0, esig, edin);
            run(s, n, 1'b0, int'(n) * 4 + 10, cyc, ok, sig, vc, din, bsy);
            check($sformatf("rnd%0d_cycles", i), 32'(cyc), 32'(int'(n) * 4 + 3));
            check($sformatf("rnd%0d_sig", i), 32'(sig), 32'(esig));
            check($sformatf("rnd%0d_vc", i), 32'(vc), 32'(n));
            check($sformatf("rnd%0d_din", i), 32'(din), 32'(edin));
            prev_sig = esig;
        end

        // abort during SETTLE of vector 3 of 10
        s = 24'($urandom) | 24'h000100;
        @(negedge clk);
        seed = s; num_vectors = 16'd10; start = 1'b1;
        cyc = 0; dcount = 0;
        while (cyc < 11) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = 1'b0;
            if (done) dcount++;
        end
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sig_kept", 32'(signature), 32'(prev_sig));
        check("abort_vc", 32'(vec_count), 32'd2);
        check("abort_din_held", 32'(dut_in), 32'(ref_lfsr(ref_lfsr(s))));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("abort_no_done", 32'(dcount), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        model(s, 16'd5, 1'b0, esig, edin);
        run(s, 16'd5, 1'b0, 40, cyc, ok, sig, vc, din, bsy);
        check("after_abort_sig", 32'(sig), 32'(esig));
        check("after_abort_cycles", 32'(cyc), 32'd23);

        // start held high for the whole run gives exactly one run
        model(24'h00ABCD, 16'd3, 1'b0, esig, edin);
        run(24'h00ABCD, 16'd3, 1'b1, 40, cyc, ok, sig, vc, din, bsy);
        check("hold_sig", 32'(sig), 32'(esig));
        check("hold_cycles", 32'(cyc), 32'd15);
        dcount = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        check("hold_single_run", 32'(dcount), 32'd0);

        // asynchronous reset while in CAPTURE
        ones_mode = 1'b1;
        @(negedge clk);
        seed = 24'h000777; num_vectors = 16'd4; start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_reset_din", 32'(dut_in), 32'h000777);
        #1 rst_n = 1'b0;
        #1;
        check("rst_dut_in", 32'(dut_in), 32'd0);
        check("rst_sig", 32'(signature), 32'd0);
        check("rst_vc", 32'(vec_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_stays_idle", 32'(busy), 32'd0);
        run(24'h000001, 16'd2, 1'b0, 40, cyc, ok, sig, vc, din, bsy);
        check("post_rst_sig", 32'(sig), 32'h0400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
